// File: rtl/xor_cipher_engine.sv
// Streaming XOR cipher stage: fetches a message from a synchronous-read source, XORs each
// word with a cyclic key (plain / chained encrypt / chained decrypt) into a cipher buffer.
module xor_cipher_engine #(
    parameter  int DATA_W  = 8,
    parameter  int DEPTH   = 16,
    parameter  int KEY_LEN = 4,
    localparam int AW      = $clog2(DEPTH),
    localparam int KW      = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1,
    localparam int LW      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [LW-1:0]     msg_len,
    input  logic [DATA_W-1:0] iv,
    input  logic              key_we,
    input  logic [KW-1:0]     key_wa,
    input  logic [DATA_W-1:0] key_wd,
    input  logic              clr,
    output logic              src_re,
    output logic [AW-1:0]     src_ra,
    input  logic [DATA_W-1:0] src_rd,
    input  logic [AW-1:0]     rd_a,
    output logic [DATA_W-1:0] rd_d,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [1:0] M_PLAIN = 2'b00;
    localparam logic [1:0] M_DEC   = 2'b10;
    localparam logic [1:0] M_ILL   = 2'b11;

    state_t            state;
    logic [1:0]        mode_q;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     len_eff;
    logic [DATA_W-1:0] prev_q;
    logic [DATA_W-1:0] ct;
    logic [KW-1:0]     key_idx;
    logic              rd_vld;
    logic [AW-1:0]     rd_idx;

    // Both arrays are padded to a power of two. Key slots >= KEY_LEN may be written but are
    // never read because key_idx wraps at KEY_LEN, so such writes are effectively ignored.
    logic [DATA_W-1:0] keys [2**KW];
    logic [DATA_W-1:0] cbuf [2**AW];

    assign len_eff = (msg_len > LW'(DEPTH)) ? LW'(DEPTH) : msg_len;
    assign ct      = src_rd ^ keys[key_idx] ^ ((mode_q == M_PLAIN) ? '0 : prev_q);
    assign rd_d    = cbuf[rd_a];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mode_q  <= M_PLAIN;
            len_q   <= '0;
            prev_q  <= '0;
            key_idx <= '0;
            rd_vld  <= 1'b0;
            rd_idx  <= '0;
            src_re  <= 1'b0;
            src_ra  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            for (int i = 0; i < 2**KW; i++) keys[i] <= '0;
            for (int i = 0; i < 2**AW; i++) cbuf[i] <= '0;
        end else begin
            done   <= 1'b0;
            rd_vld <= src_re;
            rd_idx <= src_ra;

            if (!busy && clr)
                for (int i = 0; i < 2**AW; i++) cbuf[i] <= '0;
            if (!busy && key_we)
                keys[key_wa] <= key_wd;

            // Write-back of the word returned for the address issued last cycle.
            if (rd_vld) begin
                cbuf[rd_idx] <= ct;
                prev_q       <= (mode_q == M_DEC) ? src_rd : ct;
                key_idx      <= (key_idx == KW'(KEY_LEN - 1)) ? '0 : key_idx + KW'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode == M_ILL) begin
                            err <= 1'b1;
                        end else begin
                            err     <= 1'b0;
                            mode_q  <= mode;
                            len_q   <= len_eff;
                            prev_q  <= iv;
                            key_idx <= '0;
                            if (len_eff == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state  <= RUN;
                                busy   <= 1'b1;
                                src_re <= 1'b1;
                                src_ra <= '0;
                            end
                        end
                    end
                end
                RUN: begin
                    if (LW'(src_ra) == len_q - LW'(1)) begin
                        src_re <= 1'b0;
                        state  <= DRAIN;
                    end else begin
                        src_ra <= src_ra + AW'(1);
                    end
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xor_cipher_engine.sv
// Bench for xor_cipher_engine: two instances (KEY_LEN 4 and 3) run identical jobs and are
// compared against a word-level reference model plus directed vectors.
module tb_xor_cipher_engine;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int KW    = 2;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = '0;
    logic [LW-1:0] msg_len = '0;
    logic [7:0]    iv = '0;
    logic          key_we = 1'b0;
    logic [KW-1:0] key_wa = '0;
    logic [7:0]    key_wd = '0;
    logic          clr = 1'b0;
    logic [7:0]    src_rd = '0;
    logic [AW-1:0] rd_a = '0;
    logic          src_re, busy, done, err, src_re3, busy3, done3, err3;
    logic [AW-1:0] src_ra, src_ra3;
    logic [7:0]    rd_d, rd_d3;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem  [DEPTH];
    logic [7:0] k4   [4];
    logic [7:0] k3   [3];
    logic [7:0] exp4 [DEPTH];
    logic [7:0] exp3 [DEPTH];

    xor_cipher_engine #(.DATA_W(8), .DEPTH(DEPTH), .KEY_LEN(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .msg_len(msg_len), .iv(iv),
        .key_we(key_we), .key_wa(key_wa), .key_wd(key_wd), .clr(clr),
        .src_re(src_re), .src_ra(src_ra), .src_rd(src_rd), .rd_a(rd_a), .rd_d(rd_d),
        .busy(busy), .done(done), .err(err));

    xor_cipher_engine #(.DATA_W(8), .DEPTH(DEPTH), .KEY_LEN(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .msg_len(msg_len), .iv(iv),
        .key_we(key_we), .key_wa(key_wa), .key_wd(key_wd), .clr(clr),
        .src_re(src_re3), .src_ra(src_ra3), .src_rd(src_rd), .rd_a(rd_a), .rd_d(rd_d3),
        .busy(busy3), .done(done3), .err(err3));

    always #50 clk = ~clk;

    // Source memory: one-cycle synchronous read. Both instances issue identical addresses.
    always @(posedge clk) src_rd <= src_re ? mem[src_ra] : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) k4[i] = 8'h00;
        for (int i = 0; i < 3; i++) k3[i] = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin exp4[i] = 8'h00; exp3[i] = 8'h00; end
    endtask

    task automatic model_job(input int m, input int ml, input logic [7:0] ivv, input bit c);
        int L;
        logic [7:0] p4, p3, c4, c3;
        L  = (ml > DEPTH) ? DEPTH : ml;
        p4 = ivv;
        p3 = ivv;
        if (c) for (int i = 0; i < DEPTH; i++) begin exp4[i] = 8'h00; exp3[i] = 8'h00; end
        for (int i = 0; i < L; i++) begin
            c4 = mem[i] ^ k4[i % 4] ^ ((m == 0) ? 8'h00 : p4);
            c3 = mem[i] ^ k3[i % 3] ^ ((m == 0) ? 8'h00 : p3);
            exp4[i] = c4;
            exp3[i] = c3;
            p4 = (m == 2) ? mem[i] : c4;
            p3 = (m == 2) ? mem[i] : c3;
        end
    endtask

    task automatic write_key(input int idx, input logic [7:0] val);
        key_we = 1'b1;
        key_wa = KW'(idx);
        key_wd = val;
        @(negedge clk);
        key_we = 1'b0;
        if (idx < 4) k4[idx] = val;
        if (idx < 3) k3[idx] = val;
    endtask

    task automatic check_buf(input string name);
        int bad4, bad3;
        logic [7:0] a4, a3;
        bad4 = -1; bad3 = -1; a4 = '0; a3 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_a = AW'(i);
            #1;
            if (bad4 < 0 && rd_d !== exp4[i]) begin bad4 = i; a4 = rd_d; end
            if (bad3 < 0 && rd_d3 !== exp3[i]) begin bad3 = i; a3 = rd_d3; end
        end
        checks += 2;
        if (bad4 >= 0) begin
            errors++;
            $display("FAIL %s buf(key4)[%0d]: got %0h expected %0h", name, bad4, a4, exp4[bad4]);
        end
        if (bad3 >= 0) begin
            errors++;
            $display("FAIL %s buf(key3)[%0d]: got %0h expected %0h", name, bad3, a3, exp3[bad3]);
        end
    endtask

    // Called just after a falling edge with the engine idle; returns at the falling edge of
    // the first idle cycle after done, so a following call exercises a back-to-back start.
    task automatic run_job(input int m, input int ml, input logic [7:0] ivv, input bit c,
                           input bit inj, input string name);
        int L, bad;
        logic eb, ed, er;
        L   = (ml > DEPTH) ? DEPTH : ml;
        bad = 0;
        model_job(m, ml, ivv, c);
        start   = 1'b1;
        mode    = 2'(m);
        msg_len = LW'(ml);
        iv      = ivv;
        clr     = c;
        @(negedge clk);
        start   = 1'b0;
        clr     = 1'b0;
        mode    = 2'($urandom);
        msg_len = LW'($urandom);
        iv      = 8'($urandom);
        for (int k = 1; k <= L + 3; k++) begin
            if (k > 1) @(negedge clk);
            eb = (L > 0) && (k <= L + 1);
            ed = (L == 0) ? (k == 1) : (k == L + 2);
            er = (k <= L);
            if (bad == 0 && (busy !== eb || done !== ed || src_re !== er ||
                             (er && src_ra !== AW'(k - 1)) || busy3 !== eb || done3 !== ed ||
                             src_re3 !== er || (er && src_ra3 !== AW'(k - 1))))
                bad = k;
            if (inj && k == 3) begin
                key_we = 1'b1; key_wa = '0; key_wd = 8'hEE; clr = 1'b1;
            end else begin
                key_we = 1'b0; clr = 1'b0;
            end
        end
        chk({name, " handshake first bad cycle"}, 32'(bad), 32'd0);
        chk({name, " err"}, {30'd0, err3, err}, 32'd0);
        check_buf(name);
    endtask

    typedef struct packed {
        logic [1:0]  m;
        logic [4:0]  len;
        logic [7:0]  iv;
        logic [39:0] src;   // word 0 in the LSBs
        logic [39:0] expv;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{m: 2'd0, len: 5'd5, iv: 8'h00, src: 40'h45_44_43_42_41, expv: 40'h1F_44_BC_7E_1B};
        tbl[1] = '{m: 2'd1, len: 5'd2, iv: 8'h00, src: 40'h00_00_00_42_41, expv: 40'h00_00_00_65_1B};
        tbl[2] = '{m: 2'd2, len: 5'd2, iv: 8'h00, src: 40'h00_00_00_65_1B, expv: 40'h00_00_00_42_41};
        tbl[3] = '{m: 2'd1, len: 5'd3, iv: 8'hA5, src: 40'h00_00_22_11_00, expv: 40'h00_00_0F_D2_FF};
        tbl[4] = '{m: 2'd2, len: 5'd3, iv: 8'hA5, src: 40'h00_00_0F_D2_FF, expv: 40'h00_00_22_11_00};
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("reset busy/done/err/src_re", {28'd0, busy, done, err, src_re}, 32'd0);
        chk("reset src_ra", 32'(src_ra), 32'd0);
        check_buf("reset");

        write_key(0, 8'h5A);
        write_key(1, 8'h3C);
        write_key(2, 8'hFF);
        write_key(3, 8'h00);

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < int'(tbl[t].len); i++) mem[i] = tbl[t].src[i*8 +: 8];
            run_job(int'(tbl[t].m), int'(tbl[t].len), tbl[t].iv, 1'b0, 1'b0, $sformatf("vec%0d", t));
            for (int i = 0; i < int'(tbl[t].len); i++) begin
                rd_a = AW'(i);
                #1;
                chk($sformatf("vec%0d word%0d", t, i), 32'(rd_d), 32'(tbl[t].expv[i*8 +: 8]));
            end
        end

        // Non-power-of-two key length over a full-depth message.
        write_key(0, 8'h01);
        write_key(1, 8'h02);
        write_key(2, 8'h04);
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        run_job(0, 16, 8'h00, 1'b0, 1'b0, "key3_full");
        rd_a = AW'(15);
        #1;
        chk("key3 word15", 32'(rd_d3), 32'h01);
        rd_a = AW'(5);
        #1;
        chk("key3 word5", 32'(rd_d3), 32'h04);

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        run_job(1, 0, 8'h77, 1'b0, 1'b0, "len0");
        run_job(2, 17, 8'h3D, 1'b0, 1'b0, "len_sat");

        start = 1'b1; mode = 2'b11; msg_len = LW'(5);
        @(negedge clk);
        start = 1'b0;
        chk("illegal err set", 32'(err), 32'd1);
        chk("illegal busy/src_re/done", {29'd0, busy, src_re, done}, 32'd0);
        @(negedge clk);
        chk("illegal stays idle, err sticky", {29'd0, err, busy, src_re}, 32'b100);
        run_job(0, 3, 8'h00, 1'b0, 1'b0, "after_illegal");

        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        run_job(0, 8, 8'h00, 1'b0, 1'b1, "drop_while_busy");
        run_job(1, 6, 8'h5C, 1'b1, 1'b0, "clr_with_start");

        // Reset during cycle 3 of a len=8 job.
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom) | 8'h01;
        start = 1'b1; mode = 2'b00; msg_len = LW'(8);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        chk("midreset busy/done/err/src_re", {28'd0, busy, done, err, src_re}, 32'd0);
        chk("midreset src_ra", 32'(src_ra), 32'd0);
        check_buf("midreset");
        run_job(1, 7, 8'h19, 1'b0, 1'b0, "after_midreset");

        for (int n = 0; n < 25; n++) begin
            if ($urandom_range(0, 2) == 0) write_key($urandom_range(0, 3), 8'($urandom));
            for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
            run_job($urandom_range(0, 2), $urandom_range(0, 17), 8'($urandom),
                    $urandom_range(0, 3) == 0, 1'b0, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
